// File: rtl/ascon_ctrl_fsm.sv
// Control sequencer for a one-round-per-cycle Ascon-128 permutation datapath.
// Steps the datapath through initialisation, associated data, plaintext and
// finalisation. It drives the state enable, round index and XOR/select strobes.
module ascon_ctrl_fsm #(
  parameter int unsigned ROUND_WIDTH = 4,
  parameter int unsigned A_ROUNDS    = 12,
  parameter int unsigned B_ROUNDS    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   has_ad_i,
  input  logic                   ad_valid_i,
  input  logic                   ad_last_i,
  output logic                   ad_ready_o,
  input  logic                   pt_valid_i,
  input  logic                   pt_last_i,
  output logic                   pt_ready_o,
  input  logic                   tag_ready_i,
  output logic                   en_state_o,
  output logic [ROUND_WIDTH-1:0] rnd_o,
  output logic                   sel_ad_o,
  output logic                   sel_state_init_o,
  output logic                   sel_xor_init_o,
  output logic                   sel_xor_ext_o,
  output logic                   sel_xor_dom_sep_o,
  output logic                   sel_xor_fin_o,
  output logic                   sel_xor_tag_o,
  output logic                   ct_valid_o,
  output logic                   tag_valid_o,
  output logic                   busy_o
);

  localparam logic [ROUND_WIDTH-1:0] LastRnd  = ROUND_WIDTH'(A_ROUNDS - 1);
  localparam logic [ROUND_WIDTH-1:0] FirstBlk = ROUND_WIDTH'(A_ROUNDS - B_ROUNDS);
  localparam logic [ROUND_WIDTH-1:0] One      = ROUND_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle, StInit, StWaitAd, StAdRnd, StWaitPt, StPtRnd, StFinRnd, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [ROUND_WIDTH-1:0] cnt_q, cnt_d;
  logic                   has_ad_q, has_ad_d;
  logic                   ad_last_q, ad_last_d;

  // State, round counter and latched flags; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      has_ad_q  <= 1'b0;
      ad_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      has_ad_q  <= has_ad_d;
      ad_last_q <= ad_last_d;
    end
  end

  // Next-state and combinational strobes; a handshake cycle is round 0 of its block.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    has_ad_d          = has_ad_q;
    ad_last_d         = ad_last_q;
    ad_ready_o        = 1'b0;
    pt_ready_o        = 1'b0;
    en_state_o        = 1'b0;
    rnd_o             = '0;
    sel_ad_o          = 1'b0;
    sel_state_init_o  = 1'b0;
    sel_xor_init_o    = 1'b0;
    sel_xor_ext_o     = 1'b0;
    sel_xor_dom_sep_o = 1'b0;
    sel_xor_fin_o     = 1'b0;
    sel_xor_tag_o     = 1'b0;
    ct_valid_o        = 1'b0;
    tag_valid_o       = 1'b0;
    busy_o            = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sel_state_init_o = 1'b1;
          en_state_o       = 1'b1;
          has_ad_d         = has_ad_i;
          cnt_d            = One;
          state_d          = StInit;
        end
      end
      StInit: begin
        en_state_o = 1'b1;
        rnd_o      = cnt_q;
        cnt_d      = cnt_q + One;
        if (cnt_q == LastRnd) begin
          sel_xor_init_o    = 1'b1;
          sel_xor_dom_sep_o = !has_ad_q;
          cnt_d             = '0;
          state_d           = has_ad_q ? StWaitAd : StWaitPt;
        end
      end
      StWaitAd: begin
        ad_ready_o = 1'b1;
        if (ad_valid_i) begin
          en_state_o    = 1'b1;
          sel_ad_o      = 1'b1;
          sel_xor_ext_o = 1'b1;
          rnd_o         = FirstBlk;
          ad_last_d     = ad_last_i;
          cnt_d         = FirstBlk + One;
          state_d       = StAdRnd;
        end
      end
      StAdRnd: begin
        en_state_o = 1'b1;
        sel_ad_o   = 1'b1;
        rnd_o      = cnt_q;
        cnt_d      = cnt_q + One;
        if (cnt_q == LastRnd) begin
          // Domain separation goes in after the last AD block only.
          sel_xor_dom_sep_o = ad_last_q;
          cnt_d             = '0;
          state_d           = ad_last_q ? StWaitPt : StWaitAd;
        end
      end
      StWaitPt: begin
        pt_ready_o = 1'b1;
        if (pt_valid_i) begin
          en_state_o    = 1'b1;
          sel_xor_ext_o = 1'b1;
          ct_valid_o    = 1'b1;
          if (pt_last_i) begin
            // Last block skips p^b and starts p^a finalisation at round 0.
            sel_xor_fin_o = 1'b1;
            rnd_o         = '0;
            cnt_d         = One;
            state_d       = StFinRnd;
          end else begin
            rnd_o   = FirstBlk;
            cnt_d   = FirstBlk + One;
            state_d = StPtRnd;
          end
        end
      end
      StPtRnd: begin
        en_state_o = 1'b1;
        rnd_o      = cnt_q;
        cnt_d      = cnt_q + One;
        if (cnt_q == LastRnd) begin
          cnt_d   = '0;
          state_d = StWaitPt;
        end
      end
      StFinRnd: begin
        en_state_o = 1'b1;
        rnd_o      = cnt_q;
        cnt_d      = cnt_q + One;
        if (cnt_q == LastRnd) begin
          sel_xor_tag_o = 1'b1;
          cnt_d         = '0;
          state_d       = StDone;
        end
      end
      StDone: begin
        tag_valid_o = 1'b1;
        if (tag_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // While reset is held nothing may reach the datapath.
    if (rst) begin
      ad_ready_o        = 1'b0;
      pt_ready_o        = 1'b0;
      en_state_o        = 1'b0;
      rnd_o             = '0;
      sel_ad_o          = 1'b0;
      sel_state_init_o  = 1'b0;
      sel_xor_init_o    = 1'b0;
      sel_xor_ext_o     = 1'b0;
      sel_xor_dom_sep_o = 1'b0;
      sel_xor_fin_o     = 1'b0;
      sel_xor_tag_o     = 1'b0;
      ct_valid_o        = 1'b0;
      tag_valid_o       = 1'b0;
      busy_o            = 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: builds per-cycle stimulus/expectation schedules from
// transaction-level scenario descriptions, then replays and compares every cycle.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic rst, start, has_ad, ad_valid, ad_last, pt_valid, pt_last, tag_ready;
  } stim_t;

  typedef struct packed {
    logic       busy, tag_valid, ct_valid, xtag, xfin, xdom, xext, xinit, sinit, sel_ad;
    logic [3:0] rnd;
    logic       en, pt_ready, ad_ready;
  } out_t;

  logic clk = 1'b0;
  logic rst, start_i, has_ad_i, ad_valid_i, ad_last_i, pt_valid_i, pt_last_i, tag_ready_i;
  logic ad_ready_o, pt_ready_o, en_state_o, sel_ad_o, sel_state_init_o, sel_xor_init_o;
  logic sel_xor_ext_o, sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o;
  logic ct_valid_o, tag_valid_o, busy_o;
  logic [3:0] rnd_o;
  out_t obs;

  int checks   = 0;
  int failures = 0;

  stim_t sq[$];
  out_t  eq[$];

  always #5 clk = ~clk;

  ascon_ctrl_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .has_ad_i          (has_ad_i),
    .ad_valid_i        (ad_valid_i),
    .ad_last_i         (ad_last_i),
    .ad_ready_o        (ad_ready_o),
    .pt_valid_i        (pt_valid_i),
    .pt_last_i         (pt_last_i),
    .pt_ready_o        (pt_ready_o),
    .tag_ready_i       (tag_ready_i),
    .en_state_o        (en_state_o),
    .rnd_o             (rnd_o),
    .sel_ad_o          (sel_ad_o),
    .sel_state_init_o  (sel_state_init_o),
    .sel_xor_init_o    (sel_xor_init_o),
    .sel_xor_ext_o     (sel_xor_ext_o),
    .sel_xor_dom_sep_o (sel_xor_dom_sep_o),
    .sel_xor_fin_o     (sel_xor_fin_o),
    .sel_xor_tag_o     (sel_xor_tag_o),
    .ct_valid_o        (ct_valid_o),
    .tag_valid_o       (tag_valid_o),
    .busy_o            (busy_o)
  );

  assign obs = {busy_o, tag_valid_o, ct_valid_o, sel_xor_tag_o, sel_xor_fin_o,
                sel_xor_dom_sep_o, sel_xor_ext_o, sel_xor_init_o, sel_state_init_o,
                sel_ad_o, rnd_o, en_state_o, pt_ready_o, ad_ready_o};

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Random values on every input; callers pin the ones that matter.
  function automatic stim_t noise(input bit allow_start);
    stim_t s;
    s.rst       = 1'b0;
    s.start     = allow_start ? rb() : 1'b0;
    s.has_ad    = rb();
    s.ad_valid  = rb();
    s.ad_last   = rb();
    s.pt_valid  = rb();
    s.pt_last   = rb();
    s.tag_ready = rb();
    return s;
  endfunction

  function automatic out_t busy_out();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic push(input stim_t s, input out_t o);
    sq.push_back(s);
    eq.push_back(o);
  endtask

  // Expected schedule for one whole encryption, derived from the protocol rules.
  task automatic add_scenario(input int idle, input bit has_ad, input int n_ad, input int n_pt,
                              input int gmin, input int gmax, input int tag_wait);
    stim_t s;
    out_t  o;
    int    g;
    for (int i = 0; i < idle; i++) begin
      s = noise(1'b0);
      push(s, '0);
    end
    // Start cycle: round 0 of init, still in idle so not busy.
    s = noise(1'b0); s.start = 1'b1; s.has_ad = has_ad;
    o = '0; o.sinit = 1'b1; o.en = 1'b1; o.rnd = 4'd0;
    push(s, o);
    for (int r = 1; r < 12; r++) begin
      s = noise(1'b1);
      o = busy_out(); o.en = 1'b1; o.rnd = 4'(r);
      if (r == 11) begin o.xinit = 1'b1; o.xdom = !has_ad; end
      push(s, o);
    end
    if (has_ad) begin
      for (int b = 0; b < n_ad; b++) begin
        g = $urandom_range(gmax, gmin);
        for (int i = 0; i < g; i++) begin
          s = noise(1'b1); s.ad_valid = 1'b0;
          o = busy_out(); o.ad_ready = 1'b1;
          push(s, o);
        end
        s = noise(1'b1); s.ad_valid = 1'b1; s.ad_last = (b == n_ad - 1);
        o = busy_out(); o.ad_ready = 1'b1; o.en = 1'b1; o.sel_ad = 1'b1; o.xext = 1'b1;
        o.rnd = 4'd6;
        push(s, o);
        for (int r = 7; r < 12; r++) begin
          s = noise(1'b1);
          o = busy_out(); o.en = 1'b1; o.sel_ad = 1'b1; o.rnd = 4'(r);
          o.xdom = (r == 11) && (b == n_ad - 1);
          push(s, o);
        end
      end
    end
    for (int b = 0; b < n_pt; b++) begin
      g = $urandom_range(gmax, gmin);
      for (int i = 0; i < g; i++) begin
        s = noise(1'b1); s.pt_valid = 1'b0;
        o = busy_out(); o.pt_ready = 1'b1;
        push(s, o);
      end
      s = noise(1'b1); s.pt_valid = 1'b1; s.pt_last = (b == n_pt - 1);
      o = busy_out(); o.pt_ready = 1'b1; o.en = 1'b1; o.xext = 1'b1; o.ct_valid = 1'b1;
      if (b == n_pt - 1) begin
        o.rnd = 4'd0; o.xfin = 1'b1;
        push(s, o);
        for (int r = 1; r < 12; r++) begin
          s = noise(1'b1);
          o = busy_out(); o.en = 1'b1; o.rnd = 4'(r); o.xtag = (r == 11);
          push(s, o);
        end
      end else begin
        o.rnd = 4'd6;
        push(s, o);
        for (int r = 7; r < 12; r++) begin
          s = noise(1'b1);
          o = busy_out(); o.en = 1'b1; o.rnd = 4'(r);
          push(s, o);
        end
      end
    end
    for (int i = 0; i <= tag_wait; i++) begin
      s = noise(1'b1); s.tag_ready = (i == tag_wait);
      o = busy_out(); o.tag_valid = 1'b1;
      push(s, o);
    end
  endtask

  task automatic step(input stim_t s, input out_t e, input int idx);
    @(negedge clk);
    rst         = s.rst;
    start_i     = s.start;
    has_ad_i    = s.has_ad;
    ad_valid_i  = s.ad_valid;
    ad_last_i   = s.ad_last;
    pt_valid_i  = s.pt_valid;
    pt_last_i   = s.pt_last;
    tag_ready_i = s.tag_ready;
    #2;
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL cyc%0d outputs obs=%h exp=%h stim=%h", idx, obs, e, s);
    end
  endtask

  task automatic run_queue();
    for (int i = 0; i < sq.size(); i++) step(sq[i], eq[i], i);
    sq.delete();
    eq.delete();
  endtask

  initial begin
    stim_t s;
    rst = 1'b1; start_i = 1'b1; has_ad_i = 1'b1; ad_valid_i = 1'b1; ad_last_i = 1'b0;
    pt_valid_i = 1'b1; pt_last_i = 1'b0; tag_ready_i = 1'b0;

    // Reset held with start asserted: start ignored, everything low.
    s = '0; s.rst = 1'b1; s.start = 1'b1; s.has_ad = 1'b1;
    push(s, '0); push(s, '0); push(s, '0);
    s = '0;
    push(s, '0);
    run_queue();

    // No AD, single last PT block presented immediately.
    add_scenario(0, 1'b0, 0, 1, 0, 0, 0);
    // Two AD blocks back to back, one PT block.
    add_scenario(1, 1'b1, 2, 1, 0, 0, 0);
    // Three PT blocks each preceded by a 3-cycle gap.
    add_scenario(1, 1'b0, 0, 3, 3, 3, 0);
    // Tag consumer stalls for five cycles.
    add_scenario(2, 1'b1, 1, 2, 0, 1, 5);
    run_queue();

    // Reset during AD round 9 of the first block, then a fresh run.
    add_scenario(0, 1'b1, 2, 1, 0, 0, 0);
    while (sq.size() > 16) begin
      void'(sq.pop_back());
      void'(eq.pop_back());
    end
    s = sq[15]; s.rst = 1'b1; sq[15] = s; eq[15] = '0;
    s = '0;
    push(s, '0);
    add_scenario(0, 1'b0, 0, 1, 0, 0, 0);
    run_queue();

    // Randomised encryptions.
    for (int n = 0; n < 25; n++) begin
      add_scenario($urandom_range(0, 2), rb(), $urandom_range(1, 3), $urandom_range(1, 3),
                   0, $urandom_range(0, 3), $urandom_range(0, 4));
    end
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
